// File: rtl/val2_pkg.sv
// Shared types for the val2 operand shifter: shift/mode encodings,
// the stage-1 pipeline record and the default operand width.
package val2_pkg;

  localparam int VAL2_DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_type_t;

  typedef enum logic [1:0] {
    LDST      = 2'b00,
    IMM_ROT   = 2'b01,
    IMM_SHIFT = 2'b10,
    REG_SHIFT = 2'b11
  } mode_t;

  // Decoded operation held between the two stages. The operand data itself
  // lives in a separate DATA_W-wide register because its width is a parameter.
  typedef struct packed {
    mode_t       mode;
    shift_type_t stype;
    logic [7:0]  amount;
    logic        c_in;
  } s1_rec_t;

  localparam s1_rec_t S1_REC_RESET = '{mode: LDST, stype: LSL, amount: 8'd0, c_in: 1'b0};

  // An immediate ROR with a zero amount encodes RRX; no other mode has this meaning.
  function automatic logic is_rrx(input s1_rec_t rec);
    return (rec.mode == IMM_SHIFT) && (rec.stype == ROR) && (rec.amount == 8'd0);
  endfunction

endpackage

// File: rtl/val2_shift_core.sv
// Purely combinational barrel shifter. Amount semantics are those of a
// register-specified shift (0 = pass through with c_in, >= DATA_W saturates),
// plus an explicit RRX input. All other operand modes are pre-normalised onto
// these semantics by the decode stage.
module val2_shift_core
  import val2_pkg::*;
#(
  parameter int DATA_W = VAL2_DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] data,
  input  shift_type_t       stype,
  input  logic [7:0]        amount,
  input  logic              rrx,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam int         AW      = $clog2(DATA_W);
  localparam logic [7:0] AMT_FULL = 8'(DATA_W);

  logic [DATA_W:0]   lsl_ext;
  logic [DATA_W:0]   lsr_ext;
  logic [DATA_W:0]   asr_ext;
  logic [DATA_W-1:0] ror_val;
  logic [AW-1:0]     rot;

  // Extended shifts carry the last bit shifted out in the extra bit position.
  always_comb begin
    rot     = amount[AW-1:0];
    lsl_ext = {1'b0, data} << amount;
    lsr_ext = {data, 1'b0} >> amount;
    asr_ext = $signed({data, 1'b0}) >>> amount;
    ror_val = (data >> rot) | (data << (DATA_W - int'(rot)));
    result  = data;
    carry   = c_in;
    if (rrx) begin
      result = {c_in, data[DATA_W-1:1]};
      carry  = data[0];
    end else if (amount != 8'd0) begin
      case (stype)
        LSL: begin
          if (amount < AMT_FULL) begin
            result = lsl_ext[DATA_W-1:0];
            carry  = lsl_ext[DATA_W];
          end else if (amount == AMT_FULL) begin
            result = '0;
            carry  = data[0];
          end else begin
            result = '0;
            carry  = 1'b0;
          end
        end
        LSR: begin
          if (amount < AMT_FULL) begin
            result = lsr_ext[DATA_W:1];
            carry  = lsr_ext[0];
          end else if (amount == AMT_FULL) begin
            result = '0;
            carry  = data[DATA_W-1];
          end else begin
            result = '0;
            carry  = 1'b0;
          end
        end
        ASR: begin
          if (amount < AMT_FULL) begin
            result = asr_ext[DATA_W:1];
            carry  = asr_ext[0];
          end else begin
            result = {DATA_W{data[DATA_W-1]}};
            carry  = data[DATA_W-1];
          end
        end
        ROR: begin
          if (rot == '0) begin
            result = data;
            carry  = data[DATA_W-1];
          end else begin
            result = ror_val;
            carry  = ror_val[DATA_W-1];
          end
        end
        default: begin
          result = data;
          carry  = c_in;
        end
      endcase
    end
  end

endmodule

// File: rtl/val2_shift_unit.sv
// Two-stage operand-2 generator with valid/ready handshaking.
// Stage 1 decodes the operand mode into a normalised (data, type, amount)
// record; stage 2 runs the shifter core and registers val2/carry_out.
// Optional feature macro: VAL2_REG_SHIFT_EN enables register-specified shifts;
// without it reg_shift and rs are ignored.
module val2_shift_unit
  import val2_pkg::*;
#(
  parameter int DATA_W = VAL2_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rm,
  input  logic [7:0]        rs,
  input  logic [11:0]       shift_operand,
  input  logic              imm,
  input  logic              ld_st,
  input  logic              reg_shift,
  input  logic              c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out
);

  localparam logic [7:0] AMT_FULL = 8'(DATA_W);

  s1_rec_t           dec_rec;
  logic [DATA_W-1:0] dec_data;
  s1_rec_t           s1_rec_d, s1_rec_q;
  logic [DATA_W-1:0] s1_data_d, s1_data_q;
  logic              s1_valid_d, s1_valid_q;
  logic              out_valid_d, out_valid_q;
  logic [DATA_W-1:0] val2_d, val2_q;
  logic              carry_d, carry_q;
  logic [DATA_W-1:0] core_result;
  logic              core_carry;
  logic              s2_advance;
  logic              accept;

`ifndef VAL2_REG_SHIFT_EN
  logic unused_reg_shift_inputs;
  assign unused_reg_shift_inputs = ^{reg_shift, rs};
`endif

  assign s2_advance = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_advance;
  assign accept     = in_valid && in_ready && !flush;

  assign out_valid = out_valid_q;
  assign val2      = val2_q;
  assign carry_out = carry_q;

  // Decode in priority order and fold the #0 immediate-shift special cases
  // into amounts the shifter core already understands.
  always_comb begin
    dec_rec.mode   = IMM_SHIFT;
    dec_rec.stype  = shift_type_t'(shift_operand[6:5]);
    dec_rec.amount = {3'b000, shift_operand[11:7]};
    dec_rec.c_in   = c_in;
    dec_data       = rm;
    if (ld_st) begin
      dec_rec.mode   = LDST;
      dec_rec.stype  = LSL;
      dec_rec.amount = 8'd0;
      dec_data       = {{(DATA_W-12){shift_operand[11]}}, shift_operand};
    end else if (imm) begin
      dec_rec.mode   = IMM_ROT;
      dec_rec.stype  = ROR;
      dec_rec.amount = {3'b000, shift_operand[11:8], 1'b0};
      dec_data       = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
`ifdef VAL2_REG_SHIFT_EN
    end else if (reg_shift) begin
      dec_rec.mode   = REG_SHIFT;
      dec_rec.amount = rs;
`endif
    end else if ((shift_operand[11:7] == 5'd0) && (shift_operand[6] ^ shift_operand[5])) begin
      dec_rec.amount = AMT_FULL;
    end
  end

  // Stage 1 loads whenever it is free to move on; flush empties it.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_rec_d   = s1_rec_q;
    s1_data_d  = s1_data_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_ready) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_rec_d  = dec_rec;
        s1_data_d = dec_data;
      end
    end
  end

  val2_shift_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .data  (s1_data_q),
    .stype (s1_rec_q.stype),
    .amount(s1_rec_q.amount),
    .rrx   (is_rrx(s1_rec_q)),
    .c_in  (s1_rec_q.c_in),
    .result(core_result),
    .carry (core_carry)
  );

  // Stage 2 holds its result while the consumer stalls; flush empties it.
  always_comb begin
    out_valid_d = out_valid_q;
    val2_d      = val2_q;
    carry_d     = carry_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        val2_d  = core_result;
        carry_d = core_carry;
      end
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_rec_q    <= S1_REC_RESET;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      val2_q      <= '0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_rec_q    <= s1_rec_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      val2_q      <= val2_d;
      carry_q     <= carry_d;
    end
  end

endmodule

// File: tb/tb_val2_shift_unit.sv
// Testbench for val2_shift_unit (default 32-bit width). A scoreboard model
// built from bit-serial shifting predicts every result; directed scenarios
// pin the model with hand-computed values. Follows VAL2_REG_SHIFT_EN.
module tb_val2_shift_unit;

`ifdef VAL2_REG_SHIFT_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        imm, ld_st, reg_shift, c_in, carry_out;
  logic [31:0] rm, val2;
  logic [7:0]  rs;
  logic [11:0] shift_operand;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  typedef struct {
    logic [31:0] v;
    logic        c;
    int          a;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] rm;
    logic [7:0]  rs;
    logic [11:0] so;
    logic        imm, ld, rg, c;
  } vec_t;
  vec_t tbl[10];

  val2_shift_unit dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rm           (rm),
    .rs           (rs),
    .shift_operand(shift_operand),
    .imm          (imm),
    .ld_st        (ld_st),
    .reg_shift    (reg_shift),
    .c_in         (c_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .val2         (val2),
    .carry_out    (carry_out)
  );

  // Free-running clock and edge counter used to age scoreboard entries.
  always #5 clk = ~clk;
  always @(posedge clk) ecount = ecount + 1;

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Shift one bit at a time, remembering the bit that falls off.
  function automatic logic [32:0] stepN(input logic [31:0] v0, input logic c0,
                                        input logic [1:0] t, input int n);
    logic [31:0] v;
    logic        c;
    v = v0;
    c = c0;
    for (int i = 0; i < n; i++) begin
      case (t)
        2'b00:   begin c = v[31]; v = v << 1; end
        2'b01:   begin c = v[0];  v = v >> 1; end
        2'b10:   begin c = v[0];  v = {v[31], v[31:1]}; end
        default: begin c = v[0];  v = {v[0], v[31:1]}; end
      endcase
    end
    return {c, v};
  endfunction

  function automatic logic [32:0] model(input logic [31:0] m_rm, input logic [7:0] m_rs,
                                        input logic [11:0] m_so, input logic m_imm,
                                        input logic m_ld, input logic m_reg, input logic m_c);
    logic [1:0] t;
    int         n;
    t = m_so[6:5];
    if (m_ld) return {m_c, {20{m_so[11]}}, m_so};
    if (m_imm) return stepN({24'd0, m_so[7:0]}, m_c, 2'b11, 2 * int'(m_so[11:8]));
    if (m_reg && REG_EN) return stepN(m_rm, m_c, t, int'(m_rs));
    n = int'(m_so[11:7]);
    if (n == 0 && t == 2'b11) return {m_rm[0], m_c, m_rm[31:1]};
    if (n == 0 && (t == 2'b01 || t == 2'b10)) n = 32;
    return stepN(m_rm, m_c, t, n);
  endfunction

  // Every cycle: check handshake outputs and the head result against the scoreboard.
  always @(negedge clk) begin : monitor
    logic        exp_rdy, exp_ov;
    logic [32:0] m;
    exp_t        e;
    if (rst) begin
      exp_q.delete();
    end else begin
      exp_rdy = !(exp_q.size() == 2 && !out_ready);
      exp_ov  = (exp_q.size() > 0) && (ecount >= exp_q[0].a + 1);
      checkEq("mon_in_ready", in_ready, exp_rdy);
      checkEq("mon_out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        checkEq("mon_val2", val2, exp_q[0].v);
        checkEq("mon_carry", carry_out, exp_q[0].c);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && exp_rdy) begin
        m   = model(rm, rs, shift_operand, imm, ld_st, reg_shift, c_in);
        e.v = m[31:0];
        e.c = m[32];
        e.a = ecount + 1;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation and hold it until the unit takes it.
  task automatic applyStimulus(input logic [31:0] a_rm, input logic [7:0] a_rs,
                               input logic [11:0] a_so, input logic a_imm, input logic a_ld,
                               input logic a_reg, input logic a_c);
    logic rdy;
    int   w;
    rm = a_rm; rs = a_rs; shift_operand = a_so;
    imm = a_imm; ld_st = a_ld; reg_shift = a_reg; c_in = a_c;
    in_valid = 1'b1;
    w = 0;
    do begin
      rdy = in_ready;
      tick();
      w++;
    end while (!rdy && w < 30);
    checkEq("accepted", rdy, 1);
  endtask

  // Wait for a result, compare to literals, then let it be consumed.
  task automatic checkOutput(input string name, input logic [31:0] ev, input logic ec,
                             input bit check_lat);
    int w;
    w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    checkEq({name, "_valid"}, out_valid, 1);
    if (check_lat) checkEq({name, "_latency"}, w + 1, 2);
    checkEq({name, "_val2"}, val2, ev);
    checkEq({name, "_carry"}, carry_out, ec);
    tick();
  endtask

  task automatic single(input string name, input logic [31:0] a_rm, input logic [7:0] a_rs,
                        input logic [11:0] a_so, input logic a_imm, input logic a_ld,
                        input logic a_reg, input logic a_c, input logic [31:0] ev, input logic ec);
    applyStimulus(a_rm, a_rs, a_so, a_imm, a_ld, a_reg, a_c);
    in_valid = 1'b0;
    checkOutput(name, ev, ec, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    logic [31:0] res[3];
    int          got;
    logic        rdy;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rm = '0; rs = '0; shift_operand = '0; imm = 1'b0; ld_st = 1'b0; reg_shift = 1'b0; c_in = 1'b0;
    tbl[0] = '{32'h12345678, 8'd0,  12'h2A0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{32'h80000001, 8'd0,  12'h460, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'hF0F0F0F0, 8'd40, 12'h040, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'hDEADBEEF, 8'd64, 12'h060, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h0000FFFF, 8'd1,  12'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{32'hCAFEBABE, 8'd0,  12'h020, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{32'h7FFFFFFF, 8'd31, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{32'h00000001, 8'd0,  12'hF01, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{32'h00000000, 8'd0,  12'h7FF, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{32'h80000000, 8'd0,  12'h040, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) tick();
    checkEq("rst_out_valid", out_valid, 0);
    checkEq("rst_val2", val2, 0);
    checkEq("rst_carry", carry_out, 0);
    checkEq("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    $display("[TB] directed single operations");
    single("imm_rot", 32'h0, 8'd0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFF000000, 1'b1);
    single("rrx", 32'h00000003, 8'd0, 12'h060, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000001, 1'b1);
    single("reg_lsr32", 32'h80000000, 8'd32, 12'h020, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    single("reg_lsr33", 32'h80000000, 8'd33, 12'h020, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,
           REG_EN ? 1'b0 : 1'b1);
    single("reg_lsl32", 32'h00000001, 8'd32, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0,
           REG_EN ? 32'h0 : 32'h1, REG_EN ? 1'b1 : 1'b0);
    single("ldst_c1", 32'h0, 8'd0, 12'h800, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFFF800, 1'b1);
    single("ldst_c0", 32'h0, 8'd0, 12'h800, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFF800, 1'b0);
    single("ldst_prio", 32'h0, 8'd0, 12'h800, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFFF800, 1'b0);
    single("lsl4", 32'hF000000F, 8'd0, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000000F0, 1'b1);
    single("asr1", 32'h80000001, 8'd0, 12'h0C0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC0000000, 1'b1);
    single("asr0", 32'h80000000, 8'd0, 12'h040, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1);
    single("imm_rot0", 32'h0, 8'd0, 12'h0AB, 1'b1, 1'b0, 1'b0, 1'b1, 32'h000000AB, 1'b1);

    $display("[TB] back-to-back table with consumer gaps");
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 3 != 2);
      applyStimulus(tbl[i].rm, tbl[i].rs, tbl[i].so, tbl[i].imm, tbl[i].ld, tbl[i].rg, tbl[i].c);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("[TB] stalled consumer");
    out_ready = 1'b0;
    applyStimulus(32'h0, 8'd0, 12'h001, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0, 8'd0, 12'h002, 1'b0, 1'b1, 1'b0, 1'b0);
    shift_operand = 12'h003;
    checkEq("stall_in_ready", in_ready, 0);
    tick();
    checkEq("stall_in_ready_hold", in_ready, 0);
    checkEq("stall_head_val2", val2, 32'h1);
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 12 && got < 3; k++) begin
      if (out_valid) begin
        res[got] = val2;
        got++;
      end
      rdy = in_ready;
      tick();
      if (rdy && in_valid) in_valid = 1'b0;
    end
    checkEq("stall_count", got, 3);
    checkEq("stall_order0", res[0], 32'h1);
    checkEq("stall_order1", res[1], 32'h2);
    checkEq("stall_order2", res[2], 32'h3);
    in_valid = 1'b0;
    repeat (2) tick();

    $display("[TB] flush with full pipe");
    out_ready = 1'b0;
    applyStimulus(32'h0, 8'd0, 12'h011, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0, 8'd0, 12'h022, 1'b0, 1'b1, 1'b0, 1'b0);
    shift_operand = 12'h033;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checkEq("flush_out_valid", out_valid, 0);
    checkEq("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkEq("flush_quiet", out_valid, 0);
    end

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(32'h0, 8'd0, 12'h044, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0, 8'd0, 12'h055, 1'b0, 1'b1, 1'b0, 1'b1);
    shift_operand = 12'h066;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checkEq("mrst_out_valid", out_valid, 0);
    checkEq("mrst_val2", val2, 0);
    checkEq("mrst_carry", carry_out, 0);
    checkEq("mrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkEq("mrst_quiet", out_valid, 0);
    end

    single("post_rst", 32'h0, 8'd0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFF000000, 1'b1);
    repeat (3) tick();
    checkEq("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/val2_shift_unit.md
VAL2_SHIFT_UNIT -- requirements
Module: val2_shift_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; legal values 32 or 64.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  unit accepts an input this cycle.
- rm  in  DATA_W  operand register value.
- rs  in  8  register-specified shift amount, Rs[7:0].
- shift_operand  in  12  instruction operand field.
- imm  in  1  rotated-immediate mode.
- ld_st  in  1  load/store offset mode.
- reg_shift  in  1  register-specified shift mode.
- c_in  in  1  current CPSR C flag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- val2  out  DATA_W  generated operand.
- carry_out  out  1  shifter carry.

Function
REQ-003 SHALL be a 2-stage pipeline:
- S1 registers the decoded mode, shift type and effective amount.
- S2 registers val2 and carry_out.
- Latency is 2 cycles, with throughput 1 per cycle when out_ready=1.
REQ-004 SHALL accept an input only on in_valid&&in_ready. The output transfers only on out_valid&&out_ready.
REQ-005 SHALL hold val2, carry_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-006 SHALL drive in_ready = !s1_valid || (!out_valid || out_ready), so that a full pipe with a stalled consumer deasserts in_ready. It SHALL not lose or duplicate any data.
REQ-007 SHALL decode the mode with priority ld_st > imm > reg_shift > immediate shift.
REQ-008 ld_st mode: val2 = shift_operand sign-extended from bit 11 to DATA_W, and carry_out = c_in.
REQ-009 imm mode: val2 = shift_operand[7:0] zero-extended, then rotated right by 2*shift_operand[11:8] modulo DATA_W. carry_out = c_in if the rotate amount is 0, otherwise val2[DATA_W-1].
REQ-010 Shift type comes from shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR (sign-filling), 11 ROR.
REQ-011 Immediate shift uses amount shift_operand[11:7]:
- LSL #0: rm unchanged, carry = c_in.
- LSR #0 is treated as DATA_W: result 0, carry = rm[MSB].
- ASR #0 is treated as DATA_W: result all rm[MSB], carry = rm[MSB].
- ROR #0 is RRX: {c_in, rm[MSB:1]}, carry = rm[0].
- Any nonzero n: carry = the last bit shifted out.
REQ-012 Register shift uses amount n = rs[7:0]:
- n=0: rm unchanged, carry = c_in, for every type.
- LSL/LSR with n=DATA_W: result 0, carry = rm[0] / rm[MSB] respectively.
- LSL/LSR with n>DATA_W: result 0, carry 0.
- ASR with n>=DATA_W: result all sign, carry = sign.
- ROR with n mod DATA_W = 0 and n≠0: rm unchanged, carry = rm[MSB]. Otherwise rotate by n mod DATA_W.
REQ-013 flush SHALL clear s1_valid and out_valid on the next edge. flush SHALL win over a simultaneous in_valid, and that input is dropped. in_ready SHALL be 1 in the cycle after a flush.
REQ-014 All computation SHALL be purely synchronous. There is no combinational path from in_* to val2/carry_out.

Reset
REQ-015 While rst=1, on each edge: s1_valid=0, out_valid=0, val2=0, carry_out=0.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight operations. in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-017 Macro VAL2_REG_SHIFT_EN:
- Defined: register-shift mode per REQ-012.
- Undefined: reg_shift and rs are ignored, the operation is decoded as an immediate shift per REQ-011, and no rs logic is synthesised.

Structure
REQ-018 Package val2_pkg SHALL hold:
- shift_type_t enum (LSL, LSR, ASR, ROR).
- mode_t enum (LDST, IMM_ROT, IMM_SHIFT, REG_SHIFT).
- the S1 pipeline-record struct.
- the DATA_W default constant.
REQ-019 Sub-module val2_shift_core SHALL be a purely combinational shifter (data, type, amount, c_in -> result, carry) instantiated in S2.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- imm=1, shift_operand=0x4FF -> val2=0xFF000000, carry_out=1, out_valid exactly 2 cycles after acceptance.
- Immediate ROR #0 (RRX), shift_operand=0x060, rm=0x00000003, c_in=1 -> val2=0x80000001, carry_out=1.
- reg_shift=1, LSR, rs=32, rm=0x80000000 -> val2=0, carry_out=1. Same with rs=33 -> val2=0, carry_out=0.
- ld_st=1, shift_operand=0x800 -> val2=0xFFFFF800, carry_out=c_in.
- Stall: out_ready=0 with 3 back-to-back inputs -> in_ready falls after 2 acceptances, and all 3 results emerge in order once out_ready=1.
- flush while in_valid=1 with the pipe full -> out_valid=0 next cycle, the input is dropped, and rst mid-stream gives the same result.
